// File: rtl/seg7_rx_checker.sv
// Receive-side checker for a 7-segment display link: synchronises and debounces the incoming
// segment pattern, decodes it to BCD and verifies the 0..9 wrap-around count sequence.
module seg7_rx_checker #(
    parameter logic [15:0] STABLE_CYCLES = 16'd1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg_in,
    output logic [3:0] digit,
    output logic       digit_valid,
    output logic       new_digit,
    output logic       bad_pattern,
    output logic       seq_err,
    output logic       locked,
    output logic [7:0] err_count
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        TRACK = 1'b1
    } state_t;

    // Returns {is_digit, is_blank, bcd}; anything neither digit nor blank is a bad pattern.
    function automatic logic [5:0] decode7(input logic [6:0] p);
        case (p)
            7'h3F:   decode7 = {2'b10, 4'd0};
            7'h06:   decode7 = {2'b10, 4'd1};
            7'h5B:   decode7 = {2'b10, 4'd2};
            7'h4F:   decode7 = {2'b10, 4'd3};
            7'h66:   decode7 = {2'b10, 4'd4};
            7'h6D:   decode7 = {2'b10, 4'd5};
            7'h7D:   decode7 = {2'b10, 4'd6};
            7'h07:   decode7 = {2'b10, 4'd7};
            7'h7F:   decode7 = {2'b10, 4'd8};
            7'h6F:   decode7 = {2'b10, 4'd9};
            7'h00:   decode7 = {2'b01, 4'd0};
            default: decode7 = {2'b00, 4'd0};
        endcase
    endfunction

    logic [6:0]  sync1_r;
    logic [6:0]  s_r;
    logic [6:0]  s_prev_r;
    logic [15:0] cnt_r;
    logic [6:0]  last_r;
    state_t      state_r;
    logic [3:0]  digit_r;
    logic        digit_valid_r;
    logic        new_digit_r;
    logic        bad_pattern_r;
    logic        seq_err_r;
    logic        locked_r;
    logic [7:0]  err_count_r;

    logic        accept_s;
    logic [5:0]  dec_s;
    logic        is_digit_s;
    logic        is_blank_s;
    logic [3:0]  bcd_s;
    logic [3:0]  expect_s;

    // Two-flop synchroniser for the asynchronous pins plus one delay stage for change detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r  <= 7'h00;
            s_r      <= 7'h00;
            s_prev_r <= 7'h00;
        end else begin
            sync1_r  <= seg_in;
            s_r      <= sync1_r;
            s_prev_r <= s_r;
        end
    end

    // Stability counter: restarts on any change, saturates so a stable run accepts only once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 16'd0;
        end else if (s_r != s_prev_r) begin
            cnt_r <= 16'd0;
        end else if (cnt_r != STABLE_CYCLES) begin
            cnt_r <= cnt_r + 16'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Accept fires on the cycle the counter reaches STABLE_CYCLES, unless the pattern repeats.
    always_comb begin
        accept_s   = (s_r == s_prev_r) && (cnt_r == (STABLE_CYCLES - 16'd1)) && (s_r != last_r);
        dec_s      = decode7(s_r);
        is_digit_s = dec_s[5];
        is_blank_s = dec_s[4];
        bcd_s      = dec_s[3:0];
        if (digit_r == 4'd9) begin
            expect_s = 4'd0;
        end else begin
            expect_s = digit_r + 4'd1;
        end
    end

    // Sequence-checking FSM with all outputs registered; pulses default low every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            last_r        <= 7'h00;
            digit_r       <= 4'd0;
            digit_valid_r <= 1'b0;
            new_digit_r   <= 1'b0;
            bad_pattern_r <= 1'b0;
            seq_err_r     <= 1'b0;
            locked_r      <= 1'b0;
            err_count_r   <= 8'd0;
        end else begin
            new_digit_r   <= 1'b0;
            bad_pattern_r <= 1'b0;
            seq_err_r     <= 1'b0;
            if (accept_s) begin
                last_r <= s_r;
                if (is_digit_s) begin
                    digit_r       <= bcd_s;
                    digit_valid_r <= 1'b1;
                    new_digit_r   <= 1'b1;
                    state_r       <= TRACK;
                    locked_r      <= 1'b1;
                    case (state_r)
                        TRACK: begin
                            if (bcd_s != expect_s) begin
                                seq_err_r <= 1'b1;
                                if (err_count_r != 8'hFF) begin
                                    err_count_r <= err_count_r + 8'd1;
                                end else begin
                                    err_count_r <= err_count_r;
                                end
                            end else begin
                                seq_err_r <= 1'b0;
                            end
                        end
                        default: begin
                            seq_err_r <= 1'b0;
                        end
                    endcase
                end else if (is_blank_s) begin
                    digit_valid_r <= 1'b0;
                    state_r       <= IDLE;
                    locked_r      <= 1'b0;
                end else begin
                    bad_pattern_r <= 1'b1;
                    digit_valid_r <= 1'b0;
                    state_r       <= IDLE;
                    locked_r      <= 1'b0;
                    if (err_count_r != 8'hFF) begin
                        err_count_r <= err_count_r + 8'd1;
                    end else begin
                        err_count_r <= err_count_r;
                    end
                end
            end else begin
                state_r <= state_r;
            end
        end
    end

    assign digit       = digit_r;
    assign digit_valid = digit_valid_r;
    assign new_digit   = new_digit_r;
    assign bad_pattern = bad_pattern_r;
    assign seq_err     = seq_err_r;
    assign locked      = locked_r;
    assign err_count   = err_count_r;

endmodule

// File: tb/tb_seg7_rx_checker.sv
// Self-checking bench for seg7_rx_checker: directed scenarios plus random pattern holds,
// compared against a pattern-level reference model.
module tb_seg7_rx_checker;

    localparam int ST = 4;
    localparam logic [6:0] TBL [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] seg_in = 7'h00;
    logic [3:0] digit;
    logic       digit_valid, new_digit, bad_pattern, seq_err, locked;
    logic [7:0] err_count;

    int errors = 0;
    int checks = 0;
    int nd_total = 0;

    // reference model state
    logic [6:0] m_last;
    logic [3:0] m_digit;
    logic       m_valid, m_locked;
    int         m_err;

    seg7_rx_checker #(.STABLE_CYCLES(16'(ST))) dut (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .digit(digit),
        .digit_valid(digit_valid), .new_digit(new_digit), .bad_pattern(bad_pattern),
        .seq_err(seq_err), .locked(locked), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last = 7'h00; m_digit = 4'd0; m_valid = 1'b0; m_locked = 1'b0; m_err = 0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_digit"}, 64'(digit), 64'd0);
        chk({tag, "_valid"}, 64'(digit_valid), 64'd0);
        chk({tag, "_pulses"}, 64'({new_digit, bad_pattern, seq_err}), 64'd0);
        chk({tag, "_locked"}, 64'(locked), 64'd0);
        chk({tag, "_err"}, 64'(err_count), 64'd0);
    endtask

    // Drive p for n cycles, predict the outcome from the rules, compare pulse traces and levels.
    task automatic hold(input logic [6:0] p, input int n, input string tag);
        logic [63:0] tn, tb, ts, en, eb, es;
        bit acc;
        int idx;
        tn = '0; tb = '0; ts = '0; en = '0; eb = '0; es = '0;
        acc = (n > ST) && (p != m_last);
        if (acc) begin
            m_last = p;
            idx = -1;
            for (int j = 0; j < 10; j++) if (TBL[j] == p) idx = j;
            if (idx >= 0) begin
                en = 64'd1 << (ST + 3);
                if (m_locked && idx != (m_digit + 1) % 10) begin
                    es = 64'd1 << (ST + 3);
                    m_err = (m_err < 255) ? m_err + 1 : 255;
                end
                m_digit = 4'(idx); m_valid = 1'b1; m_locked = 1'b1;
            end else if (p == 7'h00) begin
                m_valid = 1'b0; m_locked = 1'b0;
            end else begin
                eb = 64'd1 << (ST + 3);
                m_err = (m_err < 255) ? m_err + 1 : 255;
                m_valid = 1'b0; m_locked = 1'b0;
            end
        end
        seg_in = p;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk); #1;
            tn[k] = new_digit; tb[k] = bad_pattern; ts[k] = seq_err;
            if (new_digit === 1'b1) nd_total++;
        end
        chk({tag, "_new_trace"}, tn, en);
        chk({tag, "_bad_trace"}, tb, eb);
        chk({tag, "_seq_trace"}, ts, es);
        chk({tag, "_levels"}, 64'({digit, digit_valid, locked}), 64'({m_digit, m_valid, m_locked}));
        chk({tag, "_err"}, 64'(err_count), 64'(m_err));
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_zero(tag);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [6:0] g, p;
        int r;
        model_reset();
        // 1: reset state, single digit acquisition with exact latency
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        hold(7'h06, ST + 6, "t1");
        chk("t1_digit", 64'(digit), 64'd1);
        chk("t1_locked", 64'(locked), 64'd1);

        // 2: full count 0..9 and wrap, no errors
        do_reset("t2_rst");
        nd_total = 0;
        for (int i = 0; i < 11; i++) hold(TBL[i % 10], 20, "t2");
        hold(7'h06, 20, "t2_end");
        chk("t2_count", 64'(nd_total), 64'd12);
        chk("t2_err", 64'(err_count), 64'd0);

        // 3: skip a digit
        hold(7'h5B, 12, "t3a");
        hold(7'h66, 12, "t3b");
        chk("t3_err", 64'(err_count), 64'd1);
        chk("t3_digit", 64'(digit), 64'd4);

        // 4: short glitch then back to the same pattern
        hold(7'h4F, 12, "t4a");
        hold(7'h7F, 3, "t4_glitch");
        hold(7'h4F, 12, "t4b");
        chk("t4_digit", 64'(digit), 64'd3);

        // 5: bad pattern, blank, then re-acquire
        hold(7'h49, 10, "t5_bad");
        hold(7'h00, 10, "t5_blank");
        hold(7'h3F, 10, "t5_zero");
        chk("t5_locked", 64'(locked), 64'd1);

        // random holds with occasional sub-threshold glitches
        for (int i = 0; i < 40; i++) begin
            g = seg_in;
            if ($urandom_range(0, 3) == 0) begin
                g = 7'($urandom);
                if (g == seg_in) g = g ^ 7'h40;
                hold(g, $urandom_range(1, ST), "rnd_glitch");
            end
            r = $urandom_range(0, 19);
            if (r < 8)       p = TBL[(m_digit + 1) % 10];
            else if (r < 12) p = TBL[$urandom_range(0, 9)];
            else if (r < 15) p = 7'h00;
            else             p = 7'($urandom);
            if (p == g && g != seg_in) p = g ^ 7'h01;
            hold(p, $urandom_range(ST + 4, ST + 12), "rnd");
        end

        // 6: saturate err_count, then reset mid-run and re-acquire the held pattern
        for (int i = 0; i < 300; i++) hold((i % 2) ? 7'h3F : 7'h5B, ST + 4, "t6");
        chk("t6_sat", 64'(err_count), 64'hFF);
        do_reset("t6_rst");
        hold(seg_in, ST + 4, "t6_reacq");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
